// File: rtl/bcd_pkg.sv
// Shared definitions for the decimal arithmetic datapath: BCD constants,
// the serial subtractor state encoding and a digit-validity helper.
package bcd_pkg;

  localparam int BCD_MAX        = 9;
  localparam int BCD_RADIX      = 10;
  localparam int DEFAULT_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // A nibble is a legal BCD digit only in the range 0..9.
  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Request/result bundle of the serial BCD subtractor. The requester drives
// the operands and start; the subtractor returns status and the result.
interface bcd_serial_subtractor_if #(
  parameter int DIGITS = bcd_pkg::DEFAULT_DIGITS
);

  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  neg;
  logic                  err;

  modport master (
    output start, a, b,
    input  busy, done, diff, neg, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, neg, err
  );

endinterface

// File: rtl/bcd_sub_digit.sv
// Single BCD digit subtract-with-borrow: d = a_d - b_d - bin, wrapped into
// 0..9 with a borrow out whenever the raw difference goes negative.
module bcd_sub_digit
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);

  // 5-bit signed covers the full range -10..9 of the raw difference.
  logic signed [4:0] w_t;
  logic signed [4:0] w_fix;

  assign w_t = $signed({1'b0, a_d}) - $signed({1'b0, b_d}) - $signed({4'b0000, bin});

  // Add the radix back when the digit underflows and raise the borrow.
  always_comb begin
    w_fix = w_t;
    bout  = 1'b0;
    if (w_t < 0) begin
      w_fix = w_t + 5'(BCD_RADIX);
      bout  = 1'b1;
    end
  end

  assign d = w_fix[3:0];

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial multi-digit BCD subtractor producing a sign-magnitude result.
// A first pass computes A - B digit by digit; if it ends with a borrow the
// intermediate is a ten's complement, and a second pass computes 0 - diff
// to recover the magnitude.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_serial_subtractor_if.slave   bus
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = $clog2(DIGITS) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_e            r_state;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_diff;
  logic [IDXW-1:0]   r_idx;
  logic              r_borrow;
  logic              r_neg;
  logic              r_err;

  logic [DIGITS-1:0] w_bad;
  logic [3:0]        w_a_d;
  logic [3:0]        w_b_d;
  logic [3:0]        w_d;
  logic              w_bout;
  logic [W-1:0]      w_diff_upd;

  // Per-digit validity of the operands presented with start.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
    assign w_bad[gi] = digit_bad(bus.a[gi*4 +: 4]) | digit_bad(bus.b[gi*4 +: 4]);
  end

  // Select the operand digits at the current index for the shared digit unit.
  always_comb begin
    w_a_d = '0;
    w_b_d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a_d = r_a[k*4 +: 4];
        w_b_d = r_b[k*4 +: 4];
      end
    end
  end

  bcd_sub_digit u_digit (
    .a_d  (w_a_d),
    .b_d  (w_b_d),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // Result register with the freshly computed digit dropped into its slot;
  // also seeds the subtrahend of the negation pass.
  always_comb begin
    w_diff_upd = r_diff;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_diff_upd[k*4 +: 4] = w_d;
      end
    end
  end

  // Control FSM, digit index, borrow and operand/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_idx    <= '0;
            r_borrow <= 1'b0;
            r_diff   <= '0;
            r_neg    <= 1'b0;
            r_err    <= |w_bad;
            r_state  <= ST_SUB;
          end
        end
        ST_SUB: begin
          // An invalid request spends one busy cycle here and computes nothing.
          if (r_err) begin
            r_state <= ST_DONE;
          end else begin
            r_diff   <= w_diff_upd;
            r_borrow <= w_bout;
            r_idx    <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
              if (!w_bout) begin
                r_state <= ST_DONE;
              end else begin
                r_state  <= ST_NEG;
                r_idx    <= '0;
                r_borrow <= 1'b0;
                r_a      <= '0;
                r_b      <= w_diff_upd;
              end
            end
          end
        end
        ST_NEG: begin
          r_diff   <= w_diff_upd;
          r_borrow <= w_bout;
          r_idx    <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_neg   <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (r_state == ST_SUB) || (r_state == ST_NEG);
  assign bus.done = (r_state == ST_DONE);
  assign bus.diff = r_diff;
  assign bus.neg  = r_neg;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=4): a decimal-value
// reference model with latency counter checked every cycle, plus directed
// vectors with hand-computed results and latencies.
module tb_bcd_serial_subtractor;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic int bcd_val(input logic [W-1:0] v);
    int r = 0;
    for (int k = DIGITS - 1; k >= 0; k--) r = r * 10 + int'(v[k*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int x);
    logic [W-1:0] r = '0;
    int t = x;
    for (int k = 0; k < DIGITS; k++) begin
      r[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    bit bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) if (v[k*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  logic         m_busy, m_done, m_neg, m_err;
  logic [W-1:0] m_diff;
  logic         p_neg, p_err;
  logic [W-1:0] p_diff;
  int           m_cnt;

  // Model: accept start when idle, count the required busy cycles, publish result.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
      m_diff = '0;   m_neg = 1'b0;  m_err = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_diff = p_diff; m_neg = p_neg; m_err = p_err;
      end
    end else if (bus.start) begin
      int va, vb;
      va = bcd_val(bus.a);
      vb = bcd_val(bus.b);
      if (has_bad(bus.a) || has_bad(bus.b)) begin
        p_err = 1'b1; p_neg = 1'b0; p_diff = '0; m_cnt = 1;
      end else if (va >= vb) begin
        p_err = 1'b0; p_neg = 1'b0; p_diff = to_bcd(va - vb); m_cnt = DIGITS;
      end else begin
        p_err = 1'b0; p_neg = 1'b1; p_diff = to_bcd(vb - va); m_cnt = 2 * DIGITS;
      end
      m_busy = 1'b1;
    end
  end

  // Compare every cycle on the falling edge; results only when not busy.
  always @(negedge clk) begin
    check("cyc_busy", 32'(bus.busy), 32'(m_busy));
    check("cyc_done", 32'(bus.done), 32'(m_done));
    if (!m_busy) begin
      check("cyc_diff", 32'(bus.diff), 32'(m_diff));
      check("cyc_neg",  32'(bus.neg),  32'(m_neg));
      check("cyc_err",  32'(bus.err),  32'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_case(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ediff, input logic eneg,
                          input logic eerr, input int elat);
    int  n;
    bit  got;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk);                       // E0
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    got = bus.done;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      got = bus.done;
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency",   32'(n), 32'(elat));
    check("lit_diff",  32'(bus.diff), 32'(ediff));
    check("lit_neg",   32'(bus.neg),  32'(eneg));
    check("lit_err",   32'(bus.err),  32'(eerr));
    check("model_diff", 32'(m_diff), 32'(ediff));
    check("model_neg",  32'(m_neg),  32'(eneg));
    $display("txn a=%h b=%h diff=%h neg=%0b err=%0b latency=%0d",
             a, b, bus.diff, bus.neg, bus.err, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    bit got;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_neg",  32'(bus.neg),  32'd0);
    check("rst_err",  32'(bus.err),  32'd0);
    rst_n = 1'b1;
    $display("txn reset released");

    run_case(16'h4321, 16'h1234, 16'h3087, 1'b0, 1'b0, 4);
    run_case(16'h1234, 16'h4321, 16'h3087, 1'b1, 1'b0, 8);
    run_case(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4);
    run_case(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4);
    run_case(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8);
    run_case(16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0, 4);
    run_case(16'h12A4, 16'h0000, 16'h0000, 1'b0, 1'b1, 1);

    // start held high: one result per computation, restart only after done
    @(negedge clk);
    bus.a = 16'h4321; bus.b = 16'h1234; bus.start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ndone += int'(bus.done);
    end
    bus.start = 1'b0;
    check("held_done_count", 32'(ndone), 32'd2);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = bus.done;
    end
    check("held_final_done", 32'(got), 32'd1);
    $display("txn held-start a=4321 b=1234 dones_in_window=%0d diff=%h", ndone, bus.diff);

    // reset pulsed in the middle of the SUB pass
    @(negedge clk);
    bus.a = 16'h4321; bus.b = 16'h1234; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_diff", 32'(bus.diff), 32'd0);
    check("midrst_neg",  32'(bus.neg),  32'd0);
    check("midrst_err",  32'(bus.err),  32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ndone += int'(bus.done);
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    $display("txn mid-SUB reset dones_after=%0d", ndone);

    run_case(16'h0009, 16'h0003, 16'h0006, 1'b0, 1'b0, 4);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
